// File: rtl/isqrt_pkg.sv
// Shared definitions for the integer square-root core and its reconstruction checker.
package isqrt_pkg;

  localparam int WIDTH_DEF = 8;

  // State codes are shared with the square-root core.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_w(WIDTH_DEF);

endpackage

// File: rtl/isqrt_sq_step.sv
// One shift-add step of the squarer: adds mcand << shamt to acc when the multiplier bit is set.
module isqrt_sq_step
  import isqrt_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW    = CNT_W
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_mcand,
  input  logic               i_bit,
  input  logic [CW-1:0]      i_shamt,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [2*WIDTH-1:0] w_ext;
  logic [2*WIDTH-1:0] w_shifted;

  assign w_ext     = {{WIDTH{1'b0}}, i_mcand};
  assign w_shifted = w_ext << i_shamt;
  // Carry out of the top bit is dropped; it only happens for illegal remainders.
  assign o_acc     = i_bit ? (i_acc + w_shifted) : i_acc;

endmodule

// File: rtl/isqrt_reconstruct.sv
// Rebuilds N = R*R + M with one multiplier bit per clock and flags M <= 2R.
// Result appears WIDTH cycles after the input handshake and is held until accepted.
module isqrt_reconstruct
  import isqrt_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   root_in,
  input  logic [WIDTH:0]     rem_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] radicand_out,
  output logic               rem_ok
);

  localparam int            CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_rem_ok;

  isqrt_sq_step #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_step (
    .i_acc   (r_acc),
    .i_mcand (r_mcand),
    .i_bit   (r_mplier[0]),
    .i_shamt (r_cnt),
    .o_acc   (w_acc_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)       w_state_nxt = ST_CALC;
      ST_CALC: if (r_cnt == LAST)  w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready)      w_state_nxt = ST_IDLE;
      default:                     w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_rem_ok <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_mcand  <= root_in;
            r_mplier <= root_in;
            r_acc    <= {{(WIDTH-1){1'b0}}, rem_in};
            r_rem_ok <= (rem_in <= {root_in, 1'b0});
            r_cnt    <= '0;
          end
        end
        ST_CALC: begin
          r_acc    <= w_acc_nxt;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready     = (r_state == ST_IDLE);
  assign out_valid    = (r_state == ST_DONE);
  assign radicand_out = r_acc;
  assign rem_ok       = r_rem_ok;

endmodule

// File: tb/tb_isqrt_reconstruct.sv
// Bench for isqrt_reconstruct: directed scenarios plus a randomized back-to-back run against an arithmetic model.
module tb_isqrt_reconstruct;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  root_in;
  logic [8:0]  rem_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] radicand_out;
  logic        rem_ok;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  isqrt_reconstruct #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .root_in      (root_in),
    .rem_in       (rem_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .radicand_out (radicand_out),
    .rem_ok       (rem_ok)
  );

  function automatic logic [15:0] model_rad(input int r, input int m);
    return 16'((r * r + m) % 65536);
  endfunction

  function automatic logic model_ok(input int r, input int m);
    return (m <= 2 * r);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand pair and returns just after the accept edge.
  task automatic send(input logic [7:0] r, input logic [8:0] m);
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++; errs++;
      $display("FAIL send_timeout in_ready=%0b required 1", in_ready);
    end
    root_in  = r;
    rem_in   = m;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    if (!out_valid) begin
      checks++; errs++;
      $display("FAIL done_timeout out_valid=%0b required 1", out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; root_in = '0; rem_in = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (radicand_out !== 16'd0) begin errs++; $display("FAIL reset_radicand got=%0d exp=0", radicand_out); end
    checks++; if (rem_ok !== 1'b0) begin errs++; $display("FAIL reset_rem_ok got=%0b exp=0", rem_ok); end
  endtask

  task automatic test_zero();
    int lat;
    send(8'd0, 9'd0);
    wait_done(lat);
    checks++; if (lat != 8) begin errs++; $display("FAIL zero_latency got=%0d exp=8", lat); end
    checks++; if (radicand_out !== 16'd0) begin errs++; $display("FAIL zero_radicand got=%0d exp=0", radicand_out); end
    checks++; if (rem_ok !== 1'b1) begin errs++; $display("FAIL zero_rem_ok got=%0b exp=1", rem_ok); end
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errs++; $display("FAIL zero_return_idle in_ready=%0b out_valid=%0b exp 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    int lat;
    send(8'd15, 9'd7);
    wait_done(lat);
    checks++; if (lat != 8) begin errs++; $display("FAIL basic_latency got=%0d exp=8", lat); end
    checks++; if (radicand_out !== 16'd232) begin errs++; $display("FAIL basic_radicand got=%0d exp=232", radicand_out); end
    checks++; if (rem_ok !== 1'b1) begin errs++; $display("FAIL basic_rem_ok got=%0b exp=1", rem_ok); end
    tick();
  endtask

  task automatic test_bounds();
    int lat;
    send(8'd255, 9'd510);
    wait_done(lat);
    checks++; if (radicand_out !== 16'd65535) begin errs++; $display("FAIL upper_radicand got=%0d exp=65535", radicand_out); end
    checks++; if (rem_ok !== 1'b1) begin errs++; $display("FAIL upper_rem_ok got=%0b exp=1", rem_ok); end
    tick();
    send(8'd10, 9'd21);
    wait_done(lat);
    checks++; if (radicand_out !== 16'd121) begin errs++; $display("FAIL illegal_radicand got=%0d exp=121", radicand_out); end
    checks++; if (rem_ok !== 1'b0) begin errs++; $display("FAIL illegal_rem_ok got=%0b exp=0", rem_ok); end
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    send(8'd12, 9'd0);
    wait_done(lat);
    // A competing operand offered during the hold must be ignored.
    root_in = 8'd99; rem_in = 9'd3; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (out_valid !== 1'b1 || radicand_out !== 16'd144 || rem_ok !== 1'b1 || in_ready !== 1'b0) begin
        errs++;
        $display("FAIL bp_hold cyc=%0d out_valid=%0b rad=%0d rem_ok=%0b in_ready=%0b exp 1/144/1/0",
                 i, out_valid, radicand_out, rem_ok, in_ready);
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errs++; $display("FAIL bp_release out_valid=%0b in_ready=%0b exp 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_calc();
    int lat;
    bit seen = 1'b0;
    send(8'd200, 9'd5);
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || radicand_out !== 16'd0 || rem_ok !== 1'b0 || in_ready !== 1'b1) begin
      errs++; $display("FAIL abort_state out_valid=%0b rad=%0d rem_ok=%0b in_ready=%0b exp 0/0/0/1",
                       out_valid, radicand_out, rem_ok, in_ready);
    end
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    checks++; if (seen) begin errs++; $display("FAIL abort_no_output out_valid_seen=1 exp 0"); end
    send(8'd3, 9'd2);
    wait_done(lat);
    checks++; if (radicand_out !== 16'd11) begin errs++; $display("FAIL abort_next_radicand got=%0d exp=11", radicand_out); end
    checks++; if (rem_ok !== 1'b1) begin errs++; $display("FAIL abort_next_rem_ok got=%0b exp=1", rem_ok); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp_q[$];
    logic [16:0] exp_v;
    int sent = 0, got = 0, cyc = 0, last_cyc = -1;
    int r, m;
    bit acc;
    out_ready = 1'b1;
    r = $urandom_range(0, 255); m = $urandom_range(0, 511);
    root_in = 8'(r); rem_in = 9'(m); in_valid = 1'b1;
    while (got < 1000 && cyc < 15000) begin
      acc = in_valid && in_ready;
      tick();
      cyc++;
      if (acc) begin
        exp_q.push_back({model_ok(r, m), model_rad(r, m)});
        sent++;
        if (sent < 1000) begin
          r = $urandom_range(0, 255); m = $urandom_range(0, 511);
          root_in = 8'(r); rem_in = 9'(m);
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errs++; $display("FAIL b2b_unexpected rad=%0d rem_ok=%0b exp no output", radicand_out, rem_ok);
        end else begin
          exp_v = exp_q.pop_front();
          if ({rem_ok, radicand_out} !== exp_v) begin
            errs++; $display("FAIL b2b_result idx=%0d rad=%0d rem_ok=%0b exp rad=%0d rem_ok=%0b",
                             got, radicand_out, rem_ok, exp_v[15:0], exp_v[16]);
          end
        end
        if (last_cyc >= 0) begin
          checks++;
          if (cyc - last_cyc != 10) begin
            errs++; $display("FAIL b2b_interval idx=%0d got=%0d exp=10", got, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        got++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got != 1000) begin
      errs++; $display("FAIL b2b_count got=%0d exp=1000", got);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_basic();
    test_bounds();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
